// File: rtl/noc_in_port.sv
// NoC input port: one FIFO per virtual channel, round-robin output arbitration with a handshake lock,
// and credit/free pulses. Define NOC_IN_PORT_ERR_CHECK_EN to make error_o flag dropped flits (sticky).
module noc_in_port #(
  parameter int N_TOT_OF_VC   = 6,
  parameter int N_BITS_VC_ID  = 3,
  parameter int BUFFER_DEPTH  = 4,
  parameter int VC_ID_LSB     = 0,
  parameter int FLIT_TYPE_LSB = 3,
  parameter int FLIT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_WIDTH-1:0]   in_link_i,
  input  logic                    is_valid_i,
  output logic [N_TOT_OF_VC-1:0]  credit_signal_o,
  output logic [N_TOT_OF_VC-1:0]  free_signal_o,
  output logic [FLIT_WIDTH-1:0]   flit_o,
  output logic                    valid_o,
  output logic [N_BITS_VC_ID-1:0] vc_o,
  input  logic                    ready_i,
  output logic                    error_o
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = PW + 1;

  logic [FLIT_WIDTH-1:0]   mem_q [N_TOT_OF_VC][BUFFER_DEPTH];
  logic [PW-1:0]           rd_ptr_q [N_TOT_OF_VC];
  logic [PW-1:0]           rd_ptr_d [N_TOT_OF_VC];
  logic [PW-1:0]           wr_ptr_q [N_TOT_OF_VC];
  logic [PW-1:0]           wr_ptr_d [N_TOT_OF_VC];
  logic [CW-1:0]           cnt_q [N_TOT_OF_VC];
  logic [CW-1:0]           cnt_d [N_TOT_OF_VC];
  logic [N_TOT_OF_VC-1:0]  pop_s, wr_s;
  logic [N_BITS_VC_ID-1:0] wr_vc_s, vc_q, vc_d, rr_q, rr_d;
  logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
  logic [N_TOT_OF_VC-1:0]  credit_q, credit_d, free_q, free_d;
  logic                    valid_q, valid_d, hs_s, found_s;
  int                      sel_s;

  assign wr_vc_s = in_link_i[VC_ID_LSB +: N_BITS_VC_ID];
  assign hs_s    = valid_q & ready_i;

  // Per-VC push/pop decisions; out-of-range VC ids match no FIFO and are dropped.
  always_comb begin
    pop_s = '0;
    wr_s  = '0;
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      pop_s[v]    = hs_s && (vc_q == N_BITS_VC_ID'(v));
      wr_s[v]     = is_valid_i && (wr_vc_s == N_BITS_VC_ID'(v)) &&
                    ((cnt_q[v] != CW'(BUFFER_DEPTH)) || pop_s[v]);
      cnt_d[v]    = cnt_q[v] + CW'(wr_s[v]) - CW'(pop_s[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PW'(pop_s[v]);
      wr_ptr_d[v] = wr_ptr_q[v] + PW'(wr_s[v]);
    end
  end

  // Arbitration on next-cycle occupancy; a flit written into an empty VC becomes the head directly.
  always_comb begin
    rr_d    = hs_s ? vc_q : rr_q;
    valid_d = valid_q;
    vc_d    = vc_q;
    flit_d  = flit_q;
    found_s = 1'b0;
    sel_s   = 0;
    if (valid_q && !ready_i) begin
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
      for (int i = 1; i <= N_TOT_OF_VC; i++) begin
        if (!found_s && (cnt_d[(int'(rr_d) + i) % N_TOT_OF_VC] != '0)) begin
          found_s = 1'b1;
          sel_s   = (int'(rr_d) + i) % N_TOT_OF_VC;
        end else begin
          found_s = found_s;
        end
      end
      if (found_s) begin
        valid_d = 1'b1;
        vc_d    = N_BITS_VC_ID'(sel_s);
        flit_d  = (cnt_q[sel_s] == CW'(pop_s[sel_s])) ? in_link_i
                                                      : mem_q[sel_s][rd_ptr_d[sel_s]];
      end else begin
        vc_d = vc_q;
      end
    end
  end

  // Credit on every pop; free additionally when the popped flit is tail or head-tail.
  always_comb begin
    credit_d = '0;
    free_d   = '0;
    if (hs_s) begin
      credit_d = N_TOT_OF_VC'(1) << vc_q;
      free_d   = flit_q[FLIT_TYPE_LSB+1] ? (N_TOT_OF_VC'(1) << vc_q) : '0;
    end else begin
      credit_d = '0;
    end
  end

  // Flit storage (no reset: occupancy counters define validity).
  always_ff @(posedge clk) begin
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      if (wr_s[v]) mem_q[v][wr_ptr_q[v]] <= in_link_i;
    end
  end

  // FIFO pointers, arbiter state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      rr_q     <= N_BITS_VC_ID'(N_TOT_OF_VC - 1);
      valid_q  <= 1'b0;
      vc_q     <= '0;
      flit_q   <= '0;
      credit_q <= '0;
      free_q   <= '0;
    end else begin
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
        rd_ptr_q[v] <= rd_ptr_d[v];
        wr_ptr_q[v] <= wr_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
      end
      rr_q     <= rr_d;
      valid_q  <= valid_d;
      vc_q     <= vc_d;
      flit_q   <= flit_d;
      credit_q <= credit_d;
      free_q   <= free_d;
    end
  end

`ifdef NOC_IN_PORT_ERR_CHECK_EN
  logic drop_s, err_q;
  assign drop_s = is_valid_i & ~(|wr_s);

  // Sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | drop_s;
    end
  end
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign valid_o         = valid_q;
  assign vc_o            = vc_q;
  assign flit_o          = flit_q;
  assign credit_signal_o = credit_q;
  assign free_signal_o   = free_q;

endmodule
